// File: rtl/xor_pair_tx_if.sv
// Payload handshake and dual-rail line bundle for the XOR-pair transmitter.
// The master drives payload and error request; the slave returns the line and status.
interface xor_pair_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              inj_err;
    logic              a;
    logic              b;
    logic              c;
    logic              busy;
    logic [15:0]       frame_cnt;

    modport master (
        output tx_data, tx_valid, inj_err,
        input  tx_ready, a, b, c, busy, frame_cnt
    );

    modport slave (
        input  tx_data, tx_valid, inj_err,
        output tx_ready, a, b, c, busy, frame_cnt
    );
endinterface

// File: rtl/xor_pair_tx.sv
// Dual-rail (a,b) serial transmitter: one legal code (a^b=1) per payload bit, LSB first,
// optional return-to-zero spacers, a one-cycle gap per frame, and a completed-frame counter.
module xor_pair_tx #(
    parameter int DATA_W = 8,
    parameter int RTZ    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    xor_pair_tx_if.slave bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CODE, SPACE, GAP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              inj_q, inj_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              a_q, b_q, c_q;
    logic              a_d, b_d, c_d;
    logic [DATA_W-1:0] shifted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            inj_q   <= 1'b0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            inj_q   <= inj_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        inj_d   = inj_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d = CODE;
                    idx_d   = '0;
                    data_d  = bus.tx_data;
                    inj_d   = bus.inj_err;
                end
            end
            CODE: begin
                if (RTZ != 0) begin
                    state_d = SPACE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = GAP;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SPACE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = GAP;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    state_d = CODE;
                    idx_d   = idx_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line outputs are registered, so they are derived from the state being entered.
    always_comb begin
        shifted_d = data_d >> idx_d;
        a_d       = 1'b0;
        b_d       = 1'b0;
        c_d       = (state_d == CODE) || (state_d == SPACE);
        if (state_d == CODE) begin
            if (inj_d && (idx_d == LAST_IDX)) begin
                a_d = 1'b1;
                b_d = 1'b1;
            end else begin
                a_d = shifted_d[0];
                b_d = ~shifted_d[0];
            end
        end
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_xor_pair_tx.sv
// Drives three transmitter variants (8-bit RTZ, 8-bit NRZ, 1-bit RTZ) from one stimulus stream
// and compares every cycle against a frame-position model of the line protocol.
module tb_xor_pair_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic       inj_err = 1'b0;
    logic [7:0] tx_data = 8'h00;

    always #5 clk = ~clk;

    xor_pair_tx_if #(.DATA_W(8)) if0 ();
    xor_pair_tx_if #(.DATA_W(8)) if1 ();
    xor_pair_tx_if #(.DATA_W(1)) if2 ();

    assign if0.tx_data  = tx_data;
    assign if1.tx_data  = tx_data;
    assign if2.tx_data  = tx_data[0];
    assign if0.tx_valid = tx_valid;
    assign if1.tx_valid = tx_valid;
    assign if2.tx_valid = tx_valid;
    assign if0.inj_err  = inj_err;
    assign if1.inj_err  = inj_err;
    assign if2.inj_err  = inj_err;

    xor_pair_tx #(.DATA_W(8), .RTZ(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    xor_pair_tx #(.DATA_W(8), .RTZ(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    xor_pair_tx #(.DATA_W(1), .RTZ(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // Observed {a, b, c, busy, tx_ready} per variant.
    logic [4:0]  obs[3];
    logic [15:0] obs_cnt[3];
    assign obs[0] = {if0.a, if0.b, if0.c, if0.busy, if0.tx_ready};
    assign obs[1] = {if1.a, if1.b, if1.c, if1.busy, if1.tx_ready};
    assign obs[2] = {if2.a, if2.b, if2.c, if2.busy, if2.tx_ready};
    assign obs_cnt[0] = if0.frame_cnt;
    assign obs_cnt[1] = if1.frame_cnt;
    assign obs_cnt[2] = if2.frame_cnt;

    localparam int W_TAB[3]   = '{8, 8, 1};
    localparam int RTZ_TAB[3] = '{1, 0, 1};

    // Model: a frame is a sequence of positions 0..occ-1 with c=1, then position occ is the gap.
    bit          m_act[3];
    int          m_pos[3];
    logic [7:0]  m_dat[3];
    bit          m_inj[3];
    logic [15:0] m_cnt[3];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs_v, exp_v, $time);
        end
    endtask

    function automatic int occ_of(input int k);
        return (RTZ_TAB[k] != 0) ? 2 * W_TAB[k] : W_TAB[k];
    endfunction

    function automatic logic [4:0] expect_out(input int k);
        int   occ;
        int   bi;
        bit   is_code;
        logic bv;
        occ = occ_of(k);
        if (!m_act[k]) return 5'b00001;
        if (m_pos[k] == occ) return 5'b00010;
        is_code = (RTZ_TAB[k] != 0) ? (m_pos[k] % 2 == 0) : 1'b1;
        bi      = (RTZ_TAB[k] != 0) ? m_pos[k] / 2 : m_pos[k];
        if (!is_code) return 5'b00110;
        if (m_inj[k] && bi == W_TAB[k] - 1) return 5'b11110;
        bv = m_dat[k][bi];
        return {bv, ~bv, 3'b110};
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_act[k] = 1'b0;
                m_pos[k] = 0;
                m_dat[k] = 8'h00;
                m_inj[k] = 1'b0;
                m_cnt[k] = 16'h0000;
            end else if (m_act[k]) begin
                m_pos[k]++;
                if (m_pos[k] == occ_of(k)) m_cnt[k] = m_cnt[k] + 16'd1;
                if (m_pos[k] > occ_of(k)) m_act[k] = 1'b0;
            end else if (tx_valid) begin
                m_act[k] = 1'b1;
                m_pos[k] = 0;
                m_dat[k] = (W_TAB[k] == 8) ? tx_data : {7'd0, tx_data[0]};
                m_inj[k] = inj_err;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("line%0d", k), 32'(obs[k]), 32'(expect_out(k)));
            chk($sformatf("cnt%0d", k), 32'(obs_cnt[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        tx_valid = v;
        tx_data  = d;
        inj_err  = e;
        tick();
    endtask

    task automatic idle_scramble(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 1'b0;
            m_pos[k] = 0;
            m_dat[k] = 8'h00;
            m_inj[k] = 1'b0;
            m_cnt[k] = 16'h0000;
        end

        // Reset held across clock edges with a payload offered: nothing may start.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 1'b1);

        // First accept on the first edge after release.
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        inj_err  = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) drive(1'b0, 8'($urandom), 1'($urandom));
        chk("a5_frame_cnt", 32'(obs_cnt[0]), 32'd1);
        idle_scramble(4);

        // Injected MSB error on 8'h80.
        drive(1'b1, 8'h80, 1'b1);
        idle_scramble(20);

        // Valid held high: back-to-back frames at minimum spacing.
        for (int i = 0; i < 30; i++) drive(1'b1, 8'h0F, 1'b0);
        idle_scramble(20);

        // Asynchronous reset during the 4th code of an RTZ frame.
        drive(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 8'($urandom), 1'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rst_line%0d", k), 32'(obs[k]), 32'b00001);
            chk($sformatf("async_rst_cnt%0d", k), 32'(obs_cnt[k]), 32'd0);
        end
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        inj_err  = 1'b1;
        tick();
        idle_scramble(20);

        // Randomized traffic; payload and error request change every cycle.
        for (int i = 0; i < 600; i++)
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        idle_scramble(20);

        // Counter wrap from 16'hFFFF.
        @(negedge clk);
        force u_dut0.cnt_q = 16'hFFFF;
        force u_dut1.cnt_q = 16'hFFFF;
        force u_dut2.cnt_q = 16'hFFFF;
        for (int k = 0; k < 3; k++) m_cnt[k] = 16'hFFFF;
        #1;
        release u_dut0.cnt_q;
        release u_dut1.cnt_q;
        release u_dut2.cnt_q;
        tick();
        drive(1'b1, 8'h3C, 1'b0);
        idle_scramble(20);
        for (int k = 0; k < 3; k++) chk($sformatf("wrap_cnt%0d", k), 32'(obs_cnt[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
